fmul16_share_arb: RTL

- Shares one fixed-latency FP16 multiplier datapath between NUM_REQ requesters.
- Performs round-robin arbitration and valid/ready issue to the multiplier.
- Tracks each in-flight op's requester ID in a tag pipeline, then buffers results in an in-order response FIFO.
- A credit counter guarantees the non-stallable multiplier never produces a result without a FIFO slot.

---
 rtl/fmul16_arb_pkg.sv | 28 ++
 rtl/fmul16_arb_rsp_fifo.sv | 71 +++++++
 rtl/fmul16_share_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fmul16_arb_pkg.sv
// -----------------------------------------------------------------------------
// fmul16_arb_pkg
// Shared types and widths for the FP16 multiplier share/arbiter slice.
//   FP16_W / RM_W / FFLAGS_W : operand, rounding-mode and flag widths
//   ID_W                      : requester id width, sized for the largest
//                               supported requester count (8)
//   rsp_entry_t               : response FIFO entry {id, res, fflags}
//   tag_t                     : in-flight tag pipeline stage {valid, id}
// -----------------------------------------------------------------------------
package fmul16_arb_pkg;

    localparam int FP16_W   = 16;
    localparam int RM_W     = 3;
    localparam int FFLAGS_W = 5;
    localparam int ID_W     = 3;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [FP16_W-1:0]   res;
        logic [FFLAGS_W-1:0] fflags;
    } rsp_entry_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fmul16_arb_rsp_fifo.sv
// -----------------------------------------------------------------------------
// fmul16_arb_rsp_fifo
// In-order response FIFO holding multiplier results tagged with their owner.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller guarantees not full)
//   pop           : drop the head entry (caller guarantees not empty)
//   head          : current head entry, valid while !empty
//   empty, full   : occupancy status
//   count         : number of stored entries
// Push and pop in the same cycle are both performed; pointers wrap at DEPTH,
// which need not be a power of two.
// -----------------------------------------------------------------------------
import fmul16_arb_pkg::*;

module fmul16_arb_rsp_fifo #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_entry_t       push_data,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // The credit scheme upstream must make both of these impossible.
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/fmul16_share_arb.sv
// -----------------------------------------------------------------------------
// fmul16_share_arb
// Shares one fixed-latency, non-stallable FP16 multiplier between NUM_REQ
// requesters. Round-robin arbitration issues one op per cycle; a tag pipeline
// follows each op through the multiplier and its result lands in an in-order
// response FIFO. A credit counter only lets an op issue when a FIFO slot is
// guaranteed for its result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid_i/ready_o : per-requester issue handshake (ready one-hot or 0)
//   req_opa/opb/rm_i    : packed per-requester operands, requester k at slice k
//   mul_valid_o, mul_*  : issue strobe and operands to the multiplier
//   mul_res_i/fflags_i  : multiplier result, MUL_LAT cycles after issue
//   rsp_valid_o         : one-hot to the owner of the FIFO head
//   rsp_ready_i         : per-requester response ready
//   rsp_res_o/fflags_o  : head result and flags (0 when empty)
// Optional: define FMUL16_SHARE_ARB_PERF_CNT_EN to add perf_issue_cnt_o and
// perf_stall_cnt_o (32-bit wrapping issue / credit-stall counters).
// -----------------------------------------------------------------------------
import fmul16_arb_pkg::*;

module fmul16_share_arb #(
    parameter int NUM_REQ   = 2,
    parameter int MUL_LAT   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef FMUL16_SHARE_ARB_PERF_CNT_EN
    output logic [31:0]                 perf_issue_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o,
`endif
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*FP16_W-1:0]   req_opa_i,
    input  logic [NUM_REQ*FP16_W-1:0]   req_opb_i,
    input  logic [NUM_REQ*RM_W-1:0]     req_rm_i,
    output logic                        mul_valid_o,
    output logic [FP16_W-1:0]           mul_opa_o,
    output logic [FP16_W-1:0]           mul_opb_o,
    output logic [RM_W-1:0]             mul_rm_o,
    input  logic [FP16_W-1:0]           mul_res_i,
    input  logic [FFLAGS_W-1:0]         mul_fflags_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    input  logic [NUM_REQ-1:0]          rsp_ready_i,
    output logic [FP16_W-1:0]           rsp_res_o,
    output logic [FFLAGS_W-1:0]         rsp_fflags_o
);

    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int CR_W  = $clog2(OUT_DEPTH + 1);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [RR_W-1:0]  rr_ptr;
    logic [RR_W-1:0]  rr_next;
    logic [CR_W-1:0]  credit;
    logic             issue;
    logic [ID_W-1:0]  grant_id;
    tag_t             tag_q [MUL_LAT];

    logic             fifo_push;
    rsp_entry_t       fifo_push_data;
    logic             fifo_pop;
    rsp_entry_t       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Round-robin search starting at rr_ptr; gated by credit so a pop in the
    // same cycle cannot unblock an issue until the credit register updates.
    always_comb begin
        int idx;
        idx         = 0;
        req_ready_o = '0;
        issue       = 1'b0;
        grant_id    = '0;
        rr_next     = rr_ptr;
        mul_opa_o   = '0;
        mul_opb_o   = '0;
        mul_rm_o    = '0;
        if (credit != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!issue && req_valid_i[idx]) begin
                    issue            = 1'b1;
                    req_ready_o[idx] = 1'b1;
                    grant_id         = ID_W'(idx);
                    rr_next          = (idx == NUM_REQ - 1) ? '0 : RR_W'(idx + 1);
                    mul_opa_o        = req_opa_i[idx*FP16_W +: FP16_W];
                    mul_opb_o        = req_opb_i[idx*FP16_W +: FP16_W];
                    mul_rm_o         = req_rm_i[idx*RM_W +: RM_W];
                end
            end
        end
    end

    assign mul_valid_o = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            credit <= CR_W'(OUT_DEPTH);
        end else begin
            rr_ptr <= rr_next;
            case ({issue, fifo_pop})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Tag pipeline mirrors the multiplier latency; the last stage marks the
    // cycle in which mul_res_i belongs to a real op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: issue, id: grant_id};
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign fifo_push      = tag_q[MUL_LAT-1].valid;
    assign fifo_push_data = '{id: tag_q[MUL_LAT-1].id, res: mul_res_i, fflags: mul_fflags_i};

    fmul16_arb_rsp_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        rsp_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!fifo_empty && (fifo_head.id == ID_W'(k))) rsp_valid_o[k] = 1'b1;
        end
        rsp_res_o    = fifo_empty ? '0 : fifo_head.res;
        rsp_fflags_o = fifo_empty ? '0 : fifo_head.fflags;
    end

    // Only the head owner's ready matters, so a blocked head stalls everyone.
    assign fifo_pop = |(rsp_valid_o & rsp_ready_i);

    int inflight;
    always_comb begin
        inflight = 0;
        for (int i = 0; i < MUL_LAT; i++) inflight = inflight + int'(tag_q[i].valid);
    end

    a_credit_conserved: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(credit) + inflight + int'(fifo_count)) == OUT_DEPTH);
    a_full_means_no_credit: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> (credit == '0));

`ifdef FMUL16_SHARE_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (issue) perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            if (|req_valid_i && (credit == '0)) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
